// File: rtl/secure_access_pkg.sv
// Shared types and helpers for the access-controlled register bank.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package secure_access_pkg;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } gate_state_t;

    // Widest mask/uid the helper accepts; callers zero-extend into these widths.
    localparam int UID_MAX_W  = 8;
    localparam int MASK_MAX_W = 2 ** UID_MAX_W;

    // Bit u of the allow mask grants write permission to user u.
    function automatic logic is_allowed(input logic [MASK_MAX_W-1:0] mask,
                                        input logic [UID_MAX_W-1:0]  uid);
        return mask[uid];
    endfunction

endpackage

// File: rtl/access_lockout_ctrl.sv
// Consecutive-denial counter, lockout timer and OPEN/LOCKED state machine.
// Latency: events registered on the edge they are presented; outputs are flop outputs.
// Backpressure: none itself; the parent deasserts ready while locked is high.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   deny_evt     an accepted request was denied this cycle
//   grant_evt    an accepted request was granted this cycle
//   locked       lockout active
//   deny_cnt     current consecutive-denial count (holds MAX_DENY while locked)
module access_lockout_ctrl
    import secure_access_pkg::*;
#(
    parameter int MAX_DENY    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             deny_evt,
    input  logic                             grant_evt,
    output logic                             locked,
    output logic [$clog2(MAX_DENY+1)-1:0]    deny_cnt
);

    localparam int DC_W  = $clog2(MAX_DENY + 1);
    localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    gate_state_t       state_q, state_d;
    logic [DC_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        case (state_q)
            OPEN: begin
                if (grant_evt) begin
                    cnt_d = '0;
                end else if (deny_evt) begin
                    if (cnt_q != DC_W'(MAX_DENY)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // The denial that reaches the limit starts the lock; the timer
                    // counts down to zero so the lock spans LOCK_CYCLES cycles.
                    if (cnt_d == DC_W'(MAX_DENY)) begin
                        state_d = LOCKED;
                        tmr_d   = TMR_W'(LOCK_CYCLES - 1);
                    end
                end
            end
            LOCKED: begin
                if (tmr_q == '0) begin
                    state_d = OPEN;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = OPEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OPEN;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign deny_cnt = cnt_q;

endmodule

// File: rtl/secure_access_gate.sv
// Access-controlled multi-channel register bank with per-user write permission and lockout.
// Latency: 1 cycle from accepted request to rsp_valid pulse; data written on the accept edge.
// Backpressure: req_ready low for the whole lockout, driven from state only, never from req_valid.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready         write request handshake
//   req_ch, req_uid, req_wdata  target channel, requesting user, write data
//   rsp_valid, rsp_ok           one-cycle response pulse; rsp_ok=1 granted and written
//   data_out                    channel registers, ch0 in the LSBs
//   locked, deny_cnt            lockout status and consecutive-denial count
module secure_access_gate
    import secure_access_pkg::*;
#(
    parameter int                    DATA_W      = 8,
    parameter int                    UID_W       = 3,
    parameter int                    NUM_CH      = 4,
    parameter logic [(2**UID_W)-1:0] ALLOW_MASK  = 'h10,
    parameter int                    MAX_DENY    = 3,
    parameter int                    LOCK_CYCLES = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] req_ch,
    input  logic [UID_W-1:0]                         req_uid,
    input  logic [DATA_W-1:0]                        req_wdata,
    output logic                                     rsp_valid,
    output logic                                     rsp_ok,
    output logic [NUM_CH*DATA_W-1:0]                 data_out,
    output logic                                     locked,
    output logic [$clog2(MAX_DENY+1)-1:0]            deny_cnt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                           grant;
    logic                           ch_in_range;
    logic                           accept;
    logic [NUM_CH-1:0][DATA_W-1:0]  data_q, data_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic                           rsp_ok_q, rsp_ok_d;

    // Grant is decided purely from the live request, so a denial can never
    // touch the bank. The range check matters when NUM_CH is not a power of two.
    assign ch_in_range = (32'(req_ch) < 32'(NUM_CH));
    assign grant       = is_allowed(MASK_MAX_W'(ALLOW_MASK), UID_MAX_W'(req_uid)) & ch_in_range;
    assign req_ready   = ~locked;
    assign accept      = req_valid & req_ready;

    always_comb begin
        data_d      = data_q;
        rsp_valid_d = accept;
        rsp_ok_d    = accept & grant;
        if (accept && grant) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_ch == CH_W'(i)) begin
                    data_d[i] = req_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
        end else begin
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
        end
    end

    access_lockout_ctrl #(
        .MAX_DENY    (MAX_DENY),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout (
        .clk       (clk),
        .rst_n     (rst_n),
        .deny_evt  (accept & ~grant),
        .grant_evt (accept & grant),
        .locked    (locked),
        .deny_cnt  (deny_cnt)
    );

    assign data_out  = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;

endmodule

// File: tb/tb_secure_access_gate.sv
// Directed bench for secure_access_gate: default 4-channel instance plus a 3-channel instance
// for the out-of-range channel case, followed by a short random stream against a reference model.
module tb_secure_access_gate;

    logic        clk = 1'b0;
    logic        rst_n;

    // 4-channel instance
    logic        a_valid, a_ready, a_rsp_valid, a_rsp_ok, a_locked;
    logic [1:0]  a_ch;
    logic [2:0]  a_uid;
    logic [7:0]  a_wdata;
    logic [31:0] a_data;
    logic [1:0]  a_deny;

    // 3-channel instance
    logic        b_valid, b_ready, b_rsp_valid, b_rsp_ok, b_locked;
    logic [1:0]  b_ch;
    logic [2:0]  b_uid;
    logic [7:0]  b_wdata;
    logic [23:0] b_data;
    logic [1:0]  b_deny;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    secure_access_gate u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_ch    (a_ch),
        .req_uid   (a_uid),
        .req_wdata (a_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ok    (a_rsp_ok),
        .data_out  (a_data),
        .locked    (a_locked),
        .deny_cnt  (a_deny)
    );

    secure_access_gate #(.NUM_CH(3)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_ch    (b_ch),
        .req_uid   (b_uid),
        .req_wdata (b_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ok    (b_rsp_ok),
        .data_out  (b_data),
        .locked    (b_locked),
        .deny_cnt  (b_deny)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One request on instance A; returns #1 after the edge that samples it.
    task automatic req_a(input logic [2:0] uid, input logic [1:0] ch, input logic [7:0] wd);
        a_valid = 1'b1;
        a_uid   = uid;
        a_ch    = ch;
        a_wdata = wd;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Reference model state for the random stream
    logic [31:0] m_data;
    logic [1:0]  m_deny;
    logic        m_locked;
    int          m_tmr;
    logic        m_rsp_v, m_rsp_ok;

    initial begin
        int lock_cycles, ready_low, rsp_in_lock, accepts, rsps;
        logic unlocked;
        logic v, acc, g;
        logic [2:0] uid;
        logic [1:0] ch;
        logic [7:0] wd;

        rst_n   = 1'b0;
        a_valid = 1'b0; a_uid = '0; a_ch = '0; a_wdata = '0;
        b_valid = 1'b0; b_uid = '0; b_ch = '0; b_wdata = '0;

        // ---- reset state ----
        #2;
        chk("rst_data",      a_data,      32'h0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_ok",    a_rsp_ok,    0);
        chk("rst_locked",    a_locked,    0);
        chk("rst_deny",      a_deny,      0);
        chk("rst_ready",     a_ready,     1);
        #10;
        rst_n = 1'b1;

        // ---- granted write uid4 ch2 ----
        req_a(3'd4, 2'd2, 8'hA5);
        chk("g1_rsp_valid", a_rsp_valid, 1);
        chk("g1_rsp_ok",    a_rsp_ok,    1);
        chk("g1_data",      a_data,      32'h00A5_0000);
        chk("g1_deny",      a_deny,      0);

        // ---- denied write uid3 ch1 ----
        req_a(3'd3, 2'd1, 8'hFF);
        chk("d1_rsp_valid", a_rsp_valid, 1);
        chk("d1_rsp_ok",    a_rsp_ok,    0);
        chk("d1_data",      a_data,      32'h00A5_0000);
        chk("d1_deny",      a_deny,      1);

        // ---- granted write clears the denial count ----
        req_a(3'd4, 2'd0, 8'h11);
        chk("g2_rsp_ok", a_rsp_ok, 1);
        chk("g2_deny",   a_deny,   0);
        chk("g2_data",   a_data,   32'h00A5_0011);

        // ---- response is a single-cycle pulse ----
        @(posedge clk); #1;
        chk("idle_rsp_valid", a_rsp_valid, 0);

        // ---- three back-to-back denials trigger lockout ----
        req_a(3'd1, 2'd0, 8'h01);
        chk("l1_deny", a_deny, 1);
        req_a(3'd1, 2'd0, 8'h02);
        chk("l2_deny", a_deny, 2);
        req_a(3'd1, 2'd0, 8'h03);
        chk("l3_rsp_valid", a_rsp_valid, 1);
        chk("l3_rsp_ok",    a_rsp_ok,    0);
        chk("l3_locked",    a_locked,    1);
        chk("l3_ready",     a_ready,     0);
        chk("l3_data",      a_data,      32'h00A5_0011);

        // Hold an allowed request throughout the lock; it must be ignored.
        a_valid = 1'b1; a_uid = 3'd4; a_ch = 2'd3; a_wdata = 8'h77;
        lock_cycles = 1; ready_low = 1; rsp_in_lock = 0; unlocked = 1'b0;
        for (int k = 0; k < 40 && !unlocked; k++) begin
            @(posedge clk); #1;
            if (a_locked) begin
                lock_cycles++;
                if (!a_ready) ready_low++;
                if (a_rsp_valid) rsp_in_lock++;
            end else begin
                unlocked = 1'b1;
            end
        end
        a_valid = 1'b0;
        chk("lock_unlocked",    unlocked,    1);
        chk("lock_len",         lock_cycles, 16);
        chk("lock_ready_low",   ready_low,   16);
        chk("lock_no_rsp",      rsp_in_lock, 0);
        chk("unlock_rsp_valid", a_rsp_valid, 0);
        chk("unlock_deny",      a_deny,      0);
        chk("unlock_ready",     a_ready,     1);
        chk("unlock_data",      a_data,      32'h00A5_0011);

        req_a(3'd4, 2'd1, 8'h3C);
        chk("post_lock_rsp_ok", a_rsp_ok, 1);
        chk("post_lock_data",   a_data,   32'h00A5_3C11);

        // ---- out-of-range channel on the 3-channel instance ----
        b_valid = 1'b1; b_uid = 3'd4; b_ch = 2'd3; b_wdata = 8'hEE;
        @(posedge clk); #1;
        b_valid = 1'b0;
        chk("oor_rsp_valid", b_rsp_valid, 1);
        chk("oor_rsp_ok",    b_rsp_ok,    0);
        chk("oor_deny",      b_deny,      1);
        chk("oor_data",      b_data,      24'h0);
        b_valid = 1'b1; b_uid = 3'd4; b_ch = 2'd2; b_wdata = 8'h5A;
        @(posedge clk); #1;
        b_valid = 1'b0;
        chk("b_ch2_rsp_ok", b_rsp_ok, 1);
        chk("b_ch2_data",   b_data,   24'h5A_0000);
        chk("b_ch2_deny",   b_deny,   0);
        chk("b_locked",     b_locked, 0);
        chk("b_ready",      b_ready,  1);

        // ---- asynchronous reset in the middle of a lock ----
        req_a(3'd2, 2'd0, 8'h00);
        req_a(3'd2, 2'd0, 8'h00);
        req_a(3'd2, 2'd0, 8'h00);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("c5_locked", a_locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked",    a_locked,    0);
        chk("arst_deny",      a_deny,      0);
        chk("arst_data",      a_data,      32'h0);
        chk("arst_rsp_valid", a_rsp_valid, 0);
        chk("arst_ready",     a_ready,     1);
        chk("arst_b_data",    b_data,      24'h0);
        #2;
        rst_n = 1'b1;

        // ---- random stream against a reference model ----
        m_data = '0; m_deny = '0; m_locked = 1'b0; m_tmr = 0;
        accepts = 0; rsps = 0;
        for (int n = 0; n < 80; n++) begin
            v   = 1'($urandom_range(0, 1));
            uid = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
            ch  = 2'($urandom_range(0, 3));
            wd  = 8'($urandom_range(0, 255));
            acc = v && !m_locked;
            g   = (uid == 3'd4);
            a_valid = v; a_uid = uid; a_ch = ch; a_wdata = wd;
            @(posedge clk); #1;

            m_rsp_v  = acc;
            m_rsp_ok = acc && g;
            if (acc) accepts++;
            if (a_rsp_valid) rsps++;
            if (m_locked) begin
                if (m_tmr == 0) begin
                    m_locked = 1'b0;
                    m_deny   = '0;
                end else begin
                    m_tmr--;
                end
            end else if (acc && g) begin
                m_data[ch*8 +: 8] = wd;
                m_deny = '0;
            end else if (acc) begin
                if (m_deny != 2'd3) m_deny++;
                if (m_deny == 2'd3) begin
                    m_locked = 1'b1;
                    m_tmr    = 15;
                end
            end

            chk("rnd_rsp_valid", a_rsp_valid, m_rsp_v);
            if (m_rsp_v) chk("rnd_rsp_ok", a_rsp_ok, m_rsp_ok);
            chk("rnd_data",   a_data,   m_data);
            chk("rnd_locked", a_locked, m_locked);
            chk("rnd_deny",   a_deny,   m_deny);
        end
        a_valid = 1'b0;
        chk("rnd_one_rsp_per_accept", rsps, accepts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
